// File: rtl/memory_access_stage_pkg.sv
// Shared RV64I memory-stage definitions: opcodes, funct3 codes, FSM states and bus payload.
package memory_access_stage_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned IALIGN = 32;
  localparam int unsigned BUS_W  = 64;
  localparam int unsigned STRB_W = BUS_W / 8;

  localparam logic [6:0]  LOAD_INST = 7'b0000011;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Registered request payload presented on the data bus.
  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [BUS_W-1:0]  wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

  // Access size lives in funct3[1:0] for both loads and stores (3'b111 behaves as a doubleword).
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = (off[1:0] != 2'b00);
      default: mis = (off != 3'b000);
    endcase
    return mis;
  endfunction

  // Byte-lane strobes for a store of size funct3[1:0] at byte offset off.
  function automatic logic [STRB_W-1:0] store_strobe(input logic [2:0] f3, input logic [2:0] off);
    logic [STRB_W-1:0] strb;
    case (f3[1:0])
      2'b00:   strb = STRB_W'(8'h01 << off);
      2'b01:   strb = STRB_W'(8'h03 << off);
      2'b10:   strb = STRB_W'(8'h0F << off);
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/memory_access_stage_load_extract.sv
// mem_load_extract: selects the addressed bytes of a bus doubleword and sign/zero-extends them.
module mem_load_extract
  import memory_access_stage_pkg::*;
(
  input  logic [BUS_W-1:0] rdata_i,
  input  logic [2:0]       off_i,
  input  logic [2:0]       funct3_i,
  output logic [XLEN-1:0]  result_o
);

  logic [BUS_W-1:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  // Truncate to the access size and extend; LD and the unused 3'b111 pass all 64 bits.
  always_comb begin
    result_o = XLEN'(shifted);
    case (funct3_i)
      F3_LB:   result_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   result_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   result_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  result_o = {56'd0, shifted[7:0]};
      F3_LHU:  result_o = {48'd0, shifted[15:0]};
      F3_LWU:  result_o = {32'd0, shifted[31:0]};
      F3_LD:   result_o = XLEN'(shifted);
      default: result_o = XLEN'(shifted);
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// RV64I memory stage: single-outstanding load/store bus master with registered writeback.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   rd_in,
  input  logic [XLEN-1:0]   addr_in,
  input  logic [4:0]        rd_addr_in,
  input  logic              rfile_we_in,
  input  logic              memory_we_in,
  input  logic [XLEN-1:0]   current_pc_in,
  input  logic [IALIGN-1:0] current_inst_in,
  output logic              mem_ready,
  output logic [XLEN-1:0]   wb_data_out,
  output logic [4:0]        wb_addr_out,
  output logic              wb_we_out,
  output logic [XLEN-1:0]   current_pc_out,
  output logic [IALIGN-1:0] current_inst_out,
  output logic              misaligned_out,
  output logic              bus_fault_out,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [BUS_W-1:0]  bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  input  logic [BUS_W-1:0]  bus_rdata,
  input  logic              bus_ack,
  input  logic              bus_err
);

  localparam int unsigned CNT_W = 16;

  mem_state_t        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  bus_req_t          bus_q, bus_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic              wb_we_q, wb_we_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic [IALIGN-1:0] inst_out_q, inst_out_d;
  logic              misaligned_q, misaligned_d;
  logic              fault_q, fault_d;
  logic [4:0]        lat_rd_q, lat_rd_d;
  logic [2:0]        lat_f3_q, lat_f3_d;
  logic [2:0]        lat_off_q, lat_off_d;
  logic              lat_load_q, lat_load_d;
  logic [XLEN-1:0]   lat_pc_q, lat_pc_d;
  logic [IALIGN-1:0] lat_inst_q, lat_inst_d;

  logic              is_mem_c;
  logic [2:0]        f3_c;
  logic [2:0]        off_c;
  logic              mis_c;
  logic              timeout_c;
  logic [XLEN-1:0]   load_data_c;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
  logic              unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) && (CNT_W != 0);
`endif

  // Decode of the instruction offered by execute.
  assign f3_c     = current_inst_in[14:12];
  assign off_c    = addr_in[2:0];
  assign is_mem_c = memory_we_in || (current_inst_in[6:0] == LOAD_INST);
  assign mis_c    = is_misaligned(f3_c, off_c);

`ifdef MEM_TIMEOUT_EN
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  mem_load_extract u_load_extract (
    .rdata_i  (bus_rdata),
    .off_i    (lat_off_q),
    .funct3_i (lat_f3_q),
    .result_o (load_data_c)
  );

  // Next-state and next-output logic for the IDLE/WAIT handshake FSM.
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_d        = bus_q;
    wb_data_d    = wb_data_q;
    wb_addr_d    = wb_addr_q;
    wb_we_d      = 1'b0;
    pc_out_d     = pc_out_q;
    inst_out_d   = inst_out_q;
    misaligned_d = 1'b0;
    fault_d      = 1'b0;
    lat_rd_d     = lat_rd_q;
    lat_f3_d     = lat_f3_q;
    lat_off_d    = lat_off_q;
    lat_load_d   = lat_load_q;
    lat_pc_d     = lat_pc_q;
    lat_inst_d   = lat_inst_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (is_mem_c) begin
          if (mis_c) begin
            misaligned_d = 1'b1;
            pc_out_d     = current_pc_in;
            inst_out_d   = current_inst_in;
          end else begin
            state_d       = WAIT;
            bus_req_d     = 1'b1;
            bus_d.we      = memory_we_in;
            bus_d.addr    = {addr_in[XLEN-1:3], 3'b000};
            bus_d.wdata   = memory_we_in ? BUS_W'(rd_in << {off_c, 3'b000}) : '0;
            bus_d.wstrb   = memory_we_in ? store_strobe(f3_c, off_c) : '0;
            lat_rd_d      = rd_addr_in;
            lat_f3_d      = f3_c;
            lat_off_d     = off_c;
            lat_load_d    = !memory_we_in;
            lat_pc_d      = current_pc_in;
            lat_inst_d    = current_inst_in;
`ifdef MEM_TIMEOUT_EN
            cnt_d         = '0;
`endif
          end
        end else begin
          wb_data_d  = rd_in;
          wb_addr_d  = rd_addr_in;
          wb_we_d    = rfile_we_in;
          pc_out_d   = current_pc_in;
          inst_out_d = current_inst_in;
        end
      end

      WAIT: begin
        if (bus_err || bus_ack || timeout_c) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          bus_d.we   = 1'b0;
          pc_out_d   = lat_pc_q;
          inst_out_d = lat_inst_q;
          if (bus_err || timeout_c) begin
            fault_d = 1'b1;
          end else if (lat_load_q) begin
            wb_data_d = load_data_c;
            wb_addr_d = lat_rd_q;
            wb_we_d   = (lat_rd_q != 5'd0);
          end
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_q        <= '0;
      wb_data_q    <= '0;
      wb_addr_q    <= '0;
      wb_we_q      <= 1'b0;
      pc_out_q     <= '0;
      inst_out_q   <= NOP_INST;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      lat_rd_q     <= '0;
      lat_f3_q     <= '0;
      lat_off_q    <= '0;
      lat_load_q   <= 1'b0;
      lat_pc_q     <= '0;
      lat_inst_q   <= NOP_INST;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_q        <= bus_d;
      wb_data_q    <= wb_data_d;
      wb_addr_q    <= wb_addr_d;
      wb_we_q      <= wb_we_d;
      pc_out_q     <= pc_out_d;
      inst_out_q   <= inst_out_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
      lat_rd_q     <= lat_rd_d;
      lat_f3_q     <= lat_f3_d;
      lat_off_q    <= lat_off_d;
      lat_load_q   <= lat_load_d;
      lat_pc_q     <= lat_pc_d;
      lat_inst_q   <= lat_inst_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign mem_ready        = (state_q == IDLE);
  assign wb_data_out      = wb_data_q;
  assign wb_addr_out      = wb_addr_q;
  assign wb_we_out        = wb_we_q;
  assign current_pc_out   = pc_out_q;
  assign current_inst_out = inst_out_q;
  assign misaligned_out   = misaligned_q;
  assign bus_fault_out    = fault_q;
  assign bus_req          = bus_req_q;
  assign bus_we           = bus_q.we;
  assign bus_addr         = bus_q.addr;
  assign bus_wdata        = bus_q.wdata;
  assign bus_wstrb        = bus_q.wstrb;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic              clk;
  logic              rst;
  logic [63:0]       rd_in;
  logic [63:0]       addr_in;
  logic [4:0]        rd_addr_in;
  logic              rfile_we_in;
  logic              memory_we_in;
  logic [63:0]       current_pc_in;
  logic [31:0]       current_inst_in;
  logic              mem_ready;
  logic [63:0]       wb_data_out;
  logic [4:0]        wb_addr_out;
  logic              wb_we_out;
  logic [63:0]       current_pc_out;
  logic [31:0]       current_inst_out;
  logic              misaligned_out;
  logic              bus_fault_out;
  logic              bus_req;
  logic              bus_we;
  logic [63:0]       bus_addr;
  logic [63:0]       bus_wdata;
  logic [7:0]        bus_wstrb;
  logic [63:0]       bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  int vectors;
  int miscompares;

  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .rd_in            (rd_in),
    .addr_in          (addr_in),
    .rd_addr_in       (rd_addr_in),
    .rfile_we_in      (rfile_we_in),
    .memory_we_in     (memory_we_in),
    .current_pc_in    (current_pc_in),
    .current_inst_in  (current_inst_in),
    .mem_ready        (mem_ready),
    .wb_data_out      (wb_data_out),
    .wb_addr_out      (wb_addr_out),
    .wb_we_out        (wb_we_out),
    .current_pc_out   (current_pc_out),
    .current_inst_out (current_inst_out),
    .misaligned_out   (misaligned_out),
    .bus_fault_out    (bus_fault_out),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_wstrb        (bus_wstrb),
    .bus_rdata        (bus_rdata),
    .bus_ack          (bus_ack),
    .bus_err          (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [63:0] addr, input logic [63:0] data,
                       input logic [4:0] rd, input logic rf_we, input logic mem_we,
                       input logic [63:0] pc);
    current_inst_in = inst;
    addr_in         = addr;
    rd_in           = data;
    rd_addr_in      = rd;
    rfile_we_in     = rf_we;
    memory_we_in    = mem_we;
    current_pc_in   = pc;
  endtask

  task automatic drive_nop();
    drive(32'h0000_0013, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus_rdata   = 64'h0;
    bus_ack     = 1'b0;
    bus_err     = 1'b0;
    drive_nop();

    // Reset state
    step();
    step();
    rst = 1'b0;
    check("rst_bus_req", bus_req, 64'd0);
    check("rst_wb_we", wb_we_out, 64'd0);
    check("rst_inst", current_inst_out, 64'h13);
    check("rst_ready", mem_ready, 64'd1);
    check("rst_bus_addr", bus_addr, 64'd0);

    // ADDI x5 passthrough
    drive(32'h02A0_0293, 64'h0, 64'h2A, 5'd5, 1'b1, 1'b0, 64'h80);
    step();
    check("addi_data", wb_data_out, 64'h2A);
    check("addi_addr", wb_addr_out, 64'd5);
    check("addi_we", wb_we_out, 64'd1);
    check("addi_ready", mem_ready, 64'd1);
    check("addi_pc", current_pc_out, 64'h80);
    drive_nop();
    step();
    check("addi_we_pulse", wb_we_out, 64'd0);

    // LB x6 at 0x1003, ack three cycles after request
    drive(32'h0000_0303, 64'h1003, 64'h0, 5'd6, 1'b1, 1'b0, 64'h100);
    step();
    drive(32'h02A0_0293, 64'h55, 64'h77, 5'd9, 1'b1, 1'b0, 64'h999);
    check("lb_req", bus_req, 64'd1);
    check("lb_addr", bus_addr, 64'h1000);
    check("lb_we", bus_we, 64'd0);
    check("lb_ready0", mem_ready, 64'd0);
    bus_rdata = 64'h0000_0000_8000_0000;
    step();
    check("lb_ready1", mem_ready, 64'd0);
    step();
    check("lb_ready2", mem_ready, 64'd0);
    check("lb_req_held", bus_req, 64'd1);
    check("lb_wb_we_wait", wb_we_out, 64'd0);
    drive_nop();
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("lb_data", wb_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_wb_addr", wb_addr_out, 64'd6);
    check("lb_wb_we", wb_we_out, 64'd1);
    check("lb_req_drop", bus_req, 64'd0);
    check("lb_ready_back", mem_ready, 64'd1);
    check("lb_pc", current_pc_out, 64'h100);
    step();
    check("lb_wb_we_pulse", wb_we_out, 64'd0);

    // SH at 0x2006 with data 0xBEEF
    drive(32'h0000_1023, 64'h2006, 64'hBEEF, 5'd0, 1'b0, 1'b1, 64'h200);
    step();
    drive_nop();
    check("sh_strb", bus_wstrb, 64'hC0);
    check("sh_wdata", bus_wdata, 64'hBEEF_0000_0000_0000);
    check("sh_we", bus_we, 64'd1);
    check("sh_addr", bus_addr, 64'h2000);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("sh_wb_we", wb_we_out, 64'd0);
    check("sh_req_drop", bus_req, 64'd0);
    check("sh_ready", mem_ready, 64'd1);

    // SW at 0x2004 with data 0x11223344
    drive(32'h0000_2023, 64'h2004, 64'h1122_3344, 5'd0, 1'b0, 1'b1, 64'h204);
    step();
    drive_nop();
    check("sw_strb", bus_wstrb, 64'hF0);
    check("sw_wdata", bus_wdata, 64'h1122_3344_0000_0000);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("sw_ready", mem_ready, 64'd1);

    // LW x7 at 0x3002 is misaligned
    drive(32'h0000_2383, 64'h3002, 64'h0, 5'd7, 1'b1, 1'b0, 64'h300);
    step();
    drive_nop();
    check("lw_mis", misaligned_out, 64'd1);
    check("lw_mis_req", bus_req, 64'd0);
    check("lw_mis_ready", mem_ready, 64'd1);
    check("lw_mis_we", wb_we_out, 64'd0);
    step();
    check("lw_mis_pulse", misaligned_out, 64'd0);

    // LD x8 with ack and err together
    drive(32'h0000_3403, 64'h4000, 64'h0, 5'd8, 1'b1, 1'b0, 64'h400);
    step();
    drive_nop();
    check("ld_req", bus_req, 64'd1);
    bus_ack = 1'b1;
    bus_err = 1'b1;
    step();
    bus_ack = 1'b0;
    bus_err = 1'b0;
    check("ackerr_fault", bus_fault_out, 64'd1);
    check("ackerr_we", wb_we_out, 64'd0);
    check("ackerr_req", bus_req, 64'd0);
    step();
    check("ackerr_pulse", bus_fault_out, 64'd0);

    // LBU x9 at 0x5005
    drive(32'h0000_4483, 64'h5005, 64'h0, 5'd9, 1'b1, 1'b0, 64'h500);
    bus_rdata = 64'h0000_9A00_0000_0000;
    step();
    drive_nop();
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("lbu_data", wb_data_out, 64'h9A);
    check("lbu_we", wb_we_out, 64'd1);

    // LH x0 at 0x6002 accesses the bus but never writes back
    drive(32'h0000_1003, 64'h6002, 64'h0, 5'd0, 1'b1, 1'b0, 64'h600);
    bus_rdata = 64'h0000_0000_1234_0000;
    step();
    drive_nop();
    check("lhx0_req", bus_req, 64'd1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("lhx0_we", wb_we_out, 64'd0);
    check("lhx0_ready", mem_ready, 64'd1);

    // Reset during WAIT, then a late ack
    drive(32'h0000_2503, 64'h7000, 64'h0, 5'd10, 1'b1, 1'b0, 64'h700);
    step();
    drive_nop();
    check("rstw_req", bus_req, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_req_drop", bus_req, 64'd0);
    check("rstw_inst", current_inst_out, 64'h13);
    check("rstw_ready", mem_ready, 64'd1);
    check("rstw_fault", bus_fault_out, 64'd0);
    bus_ack = 1'b1;
    bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus_ack = 1'b0;
    check("rstw_late_ack_we", wb_we_out, 64'd0);
    check("rstw_late_ack_fault", bus_fault_out, 64'd0);

    // Unacknowledged LD at 0x8000
    drive(32'h0000_3583, 64'h8000, 64'h0, 5'd11, 1'b1, 1'b0, 64'h800);
    step();
    drive_nop();
    for (int i = 0; i < 3; i++) begin
      step();
      check("noack_req_held", bus_req, 64'd1);
    end
`ifdef MEM_TIMEOUT_EN
    step();
    check("timeout_fault", bus_fault_out, 64'd1);
    check("timeout_req", bus_req, 64'd0);
    check("timeout_ready", mem_ready, 64'd1);
`else
    for (int i = 0; i < 8; i++) step();
    check("noack_still_waiting", bus_req, 64'd1);
    check("noack_no_fault", bus_fault_out, 64'd0);
    bus_ack = 1'b1;
    bus_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    bus_ack = 1'b0;
    check("noack_late_data", wb_data_out, 64'h0123_4567_89AB_CDEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
